iq_modulator: RTL and testbench

Transmit-side counterpart of the IQ demodulation chain. Accepts baseband I/Q sample pairs at the low rate over a valid/ready handshake and holds each pair for N clk_in cycles (zero-order-hold interpolation). It mixes the held pair against a quadrature LO from two DDS_Gen instances and outputs the real passband sample RF = I·cos − Q·sin, scaled and saturated, every clk_in cycle.

---
 rtl/iq_modulator.sv | 196 +++++++++++++++++++
 tb/tb_iq_modulator.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_modulator.sv
// Zero-order-hold I/Q upsampler and quadrature mixer producing RF = I*cos - Q*sin.
// Latency: held sample to RF_OUT is 2 clk_in edges. One-pair skid buffer; s_ready opens when the buffer is empty or drains at the wrap.
// Backpressure: s_ready is combinational from en, buffer state and the hold counter; no other stalls.

// Free-running DDS with a parabolic sine: exact at 0/90/180/270 degrees, one register of latency.
// Latency: output is registered one edge after the phase accumulator.
// Backpressure: none; runs every cycle and is never reset.
module DDS_Gen #(
   parameter int OUTPUT_WIDTH = 12,
   parameter int PHASE_WIDTH  = 32
) (
   input  logic                           clk_in,
   input  logic [PHASE_WIDTH-1:0]         Fre_word,
   input  logic [PHASE_WIDTH-1:0]         Pha_word,
   output logic signed [OUTPUT_WIDTH-1:0] wave_out
);
   localparam logic [63:0] AMP = 64'((1 << (OUTPUT_WIDTH - 1)) - 1);

   logic [PHASE_WIDTH-1:0]         acc;
   logic [15:0]                    ph;
   logic signed [OUTPUT_WIDTH-1:0] mag;

   always_ff @(posedge clk_in) begin
      acc <= acc + Fre_word;
   end

   // ph[15] selects the negative half-wave; 4p(1-p) over the half-wave gives the magnitude.
   assign ph  = 16'((acc + Pha_word) >> (PHASE_WIDTH - 16));
   assign mag = OUTPUT_WIDTH'((64'(ph[14:0]) * (64'd32768 - 64'(ph[14:0])) * AMP) >> 28);

   always_ff @(posedge clk_in) begin
      wave_out <= ph[15] ? -mag : mag;
   end
endmodule

module iq_modulator #(
   parameter int INPUT_WIDTH  = 12,
   parameter int OUTPUT_WIDTH = 12,
   parameter int CNT_WIDTH    = 10,
   parameter int LO_WIDTH     = 12
) (
   input  logic                           clk_in,
   input  logic                           RST,
   input  logic                           en,
   input  logic [31:0]                    LO_fre,
   input  logic [CNT_WIDTH-1:0]           N,
   input  logic signed [INPUT_WIDTH-1:0]  I_IN,
   input  logic signed [INPUT_WIDTH-1:0]  Q_IN,
   input  logic                           s_valid,
   output logic                           s_ready,
   output logic signed [OUTPUT_WIDTH-1:0] RF_OUT,
   output logic                           sample_tick,
   output logic                           underflow
);
   localparam int PW = INPUT_WIDTH + LO_WIDTH;
   localparam int SW = PW + 1;
   localparam logic signed [SW-1:0] LIM_HI = SW'((2 ** (OUTPUT_WIDTH - 1)) - 1);
   localparam logic signed [SW-1:0] LIM_LO = SW'(-(2 ** (OUTPUT_WIDTH - 1)));

   typedef enum logic [1:0] {IDLE, RUN, UNDERRUN} state_t;

   logic signed [LO_WIDTH-1:0]    lo_sin, lo_cos;
   logic [CNT_WIDTH-1:0]          cnt, neff;
   logic                          wrap, accept;
   logic signed [INPUT_WIDTH-1:0] buf_i, buf_q, cur_i, cur_q, cur_i_d, cur_q_d;
   logic                          buf_valid;
   state_t                        state, state_d;
   logic                          underflow_d, tick_d;
   logic signed [PW-1:0]          p_i, p_q;
   logic signed [SW-1:0]          sum, shr;
   logic signed [OUTPUT_WIDTH-1:0] rf_d;

   DDS_Gen #(.OUTPUT_WIDTH(LO_WIDTH), .PHASE_WIDTH(32)) u_lo_sin (
      .clk_in   (clk_in),
      .Fre_word (LO_fre),
      .Pha_word (32'h0000_0000),
      .wave_out (lo_sin)
   );

   DDS_Gen #(.OUTPUT_WIDTH(LO_WIDTH), .PHASE_WIDTH(32)) u_lo_cos (
      .clk_in   (clk_in),
      .Fre_word (LO_fre),
      .Pha_word (32'h4000_0000),
      .wave_out (lo_cos)
   );

   // >= rather than == so a shrinking N mid-hold wraps at once instead of counting through the rollover.
   assign neff    = (N == '0) ? CNT_WIDTH'(1) : N;
   assign wrap    = (cnt >= neff - CNT_WIDTH'(1));
   assign s_ready = en && (!buf_valid || wrap);
   assign accept  = s_valid && s_ready;

   always_ff @(posedge clk_in or negedge RST) begin
      if (!RST) begin
         cnt       <= '0;
         buf_valid <= 1'b0;
         buf_i     <= '0;
         buf_q     <= '0;
      end else if (!en) begin
         cnt       <= '0;
         buf_valid <= 1'b0;
      end else begin
         cnt <= wrap ? '0 : cnt + CNT_WIDTH'(1);
         if (accept) begin
            buf_i     <= I_IN;
            buf_q     <= Q_IN;
            buf_valid <= 1'b1;
         end else if (wrap) begin
            buf_valid <= 1'b0;
         end
      end
   end

   always_comb begin
      state_d     = state;
      cur_i_d     = cur_i;
      cur_q_d     = cur_q;
      underflow_d = underflow;
      tick_d      = 1'b0;
      if (!en) begin
         state_d     = IDLE;
         cur_i_d     = '0;
         cur_q_d     = '0;
         underflow_d = 1'b0;
      end else if (wrap) begin
         if (buf_valid) begin
            cur_i_d = buf_i;
            cur_q_d = buf_q;
            tick_d  = 1'b1;
            state_d = RUN;
         end else begin
            cur_i_d = '0;
            cur_q_d = '0;
            case (state)
               IDLE:     state_d = IDLE;
               RUN: begin
                  state_d     = UNDERRUN;
                  underflow_d = 1'b1;
               end
               UNDERRUN: state_d = UNDERRUN;
               default:  state_d = IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk_in or negedge RST) begin
      if (!RST) begin
         state       <= IDLE;
         cur_i       <= '0;
         cur_q       <= '0;
         underflow   <= 1'b0;
         sample_tick <= 1'b0;
      end else begin
         state       <= state_d;
         cur_i       <= cur_i_d;
         cur_q       <= cur_q_d;
         underflow   <= underflow_d;
         sample_tick <= tick_d;
      end
   end

   // Products are cleared while disabled so RF_OUT settles to zero two edges after en falls.
   always_ff @(posedge clk_in or negedge RST) begin
      if (!RST) begin
         p_i <= '0;
         p_q <= '0;
      end else if (!en) begin
         p_i <= '0;
         p_q <= '0;
      end else begin
         p_i <= PW'(cur_i) * PW'(lo_cos);
         p_q <= PW'(cur_q) * PW'(lo_sin);
      end
   end

   assign sum = SW'(p_i) - SW'(p_q);
   assign shr = sum >>> (LO_WIDTH - 1);

   always_comb begin
      rf_d = shr[OUTPUT_WIDTH-1:0];
      if (shr > LIM_HI) begin
         rf_d = LIM_HI[OUTPUT_WIDTH-1:0];
      end else if (shr < LIM_LO) begin
         rf_d = LIM_LO[OUTPUT_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk_in or negedge RST) begin
      if (!RST) begin
         RF_OUT <= '0;
      end else begin
         RF_OUT <= rf_d;
      end
   end
endmodule

// File: tb/tb_iq_modulator.sv
// Bench for iq_modulator: a 12-bit and a 10-bit output instance share stimulus; expectations come from sample order and timing rules.
module tb_iq_modulator;
   localparam int AMP = 2047;

   logic clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   logic               RST, en, s_valid;
   logic [31:0]        LO_fre;
   logic [9:0]         N;
   logic signed [11:0] I_IN, Q_IN;
   logic               s_ready12, s_ready10, tick12, tick10, uf12, uf10;
   logic signed [11:0] rf12;
   logic signed [9:0]  rf10;

   int errors = 0;
   int checks = 0;

   iq_modulator #(.INPUT_WIDTH(12), .OUTPUT_WIDTH(12), .CNT_WIDTH(10), .LO_WIDTH(12)) u_dut12 (
      .clk_in(clk_in), .RST(RST), .en(en), .LO_fre(LO_fre), .N(N), .I_IN(I_IN), .Q_IN(Q_IN),
      .s_valid(s_valid), .s_ready(s_ready12), .RF_OUT(rf12), .sample_tick(tick12), .underflow(uf12)
   );

   iq_modulator #(.INPUT_WIDTH(12), .OUTPUT_WIDTH(10), .CNT_WIDTH(10), .LO_WIDTH(12)) u_dut10 (
      .clk_in(clk_in), .RST(RST), .en(en), .LO_fre(LO_fre), .N(N), .I_IN(I_IN), .Q_IN(Q_IN),
      .s_valid(s_valid), .s_ready(s_ready10), .RF_OUT(rf10), .sample_tick(tick10), .underflow(uf10)
   );

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // RF = sat((I*cos - Q*sin) / 2^11), rounding toward minus infinity.
   function automatic int exp_rf(input int i, input int q, input int c, input int s, input int ow);
      longint v, hi, lo;
      v  = longint'(i) * c - longint'(q) * s;
      v  = v >>> 11;
      hi = (longint'(1) << (ow - 1)) - 1;
      lo = -hi - 1;
      if (v > hi) v = hi;
      if (v < lo) v = lo;
      return int'(v);
   endfunction

   function automatic int gen_i();
      int v;
      v = int'($urandom_range(4095)) - 2048;
      if (v > -16 && v < 16) v = v + 100;
      return v;
   endfunction

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic check_out(input string tag, input int v);
      check({tag, "_rf12"}, rf12, exp_rf(v, 0, AMP, 0, 12));
      check({tag, "_rf10"}, rf10, exp_rf(v, 0, AMP, 0, 10));
   endtask

   task automatic check_ctl(input string tag, input int tick_e, input int uf_e);
      check({tag, "_tick12"}, tick12, tick_e);
      check({tag, "_tick10"}, tick10, tick_e);
      check({tag, "_uf12"}, uf12, uf_e);
      check({tag, "_uf10"}, uf10, uf_e);
   endtask

   task automatic flush();
      s_valid = 1'b0;
      en = 1'b0;
      step();
      en = 1'b1;
   endtask

   task automatic single_pair(input int iv, input int qv, input int n_val, input bit do_flush);
      int neff;
      neff = n_val;
      if (do_flush) flush();
      N = 10'(n_val);
      I_IN = 12'(iv);
      Q_IN = 12'(qv);
      s_valid = 1'b1;
      for (int t = 1; t <= 2 * neff + 3; t++) begin
         step();
         if (t == 1) s_valid = 1'b0;
         check_ctl("pair", int'(t == neff), int'(t >= 2 * neff));
         if (t >= 2) check_out("pair", (t >= neff + 2 && t <= 2 * neff + 1) ? iv : 0);
      end
   endtask

   task automatic stream(input int n_val, input int nsamp);
      int neff, t, checked, bad_tick, bad_acc, e;
      int acc_q[$];
      int acc_t[$];
      int tick_t[$];
      int due_t[$];
      int due_v[$];
      bit will;
      neff = (n_val == 0) ? 1 : n_val;
      flush();
      N = 10'(n_val);
      I_IN = 12'(gen_i());
      Q_IN = 12'($urandom_range(4095));
      s_valid = 1'b1;
      #1;
      will = s_ready12;
      checked = 0;
      t = 0;
      while (checked < nsamp && t < nsamp * neff * 2 + 20) begin
         step();
         t++;
         if (will) begin
            acc_q.push_back(int'(I_IN));
            acc_t.push_back(t);
            I_IN = 12'(gen_i());
            Q_IN = 12'($urandom_range(4095));
         end
         if (tick12) begin
            tick_t.push_back(t);
            check("stream_tick_has_data", int'(acc_q.size() > 0), 1);
            if (acc_q.size() > 0) begin
               due_t.push_back(t + 2);
               due_v.push_back(acc_q.pop_front());
            end
         end
         if (due_t.size() > 0 && due_t[0] == t) begin
            e = due_v.pop_front();
            void'(due_t.pop_front());
            check_out("stream", e);
            checked++;
         end
         #1;
         will = s_ready12;
      end
      check("stream_count", checked, nsamp);
      check("stream_uf12", uf12, 0);
      check("stream_uf10", uf10, 0);
      bad_tick = 0;
      for (int i = 1; i < tick_t.size(); i++) if (tick_t[i] - tick_t[i-1] != neff) bad_tick++;
      check("stream_tick_period", bad_tick, 0);
      bad_acc = 0;
      for (int i = 2; i < acc_t.size(); i++) if (acc_t[i] - acc_t[i-1] != neff) bad_acc++;
      check("stream_accept_period", bad_acc, 0);
      s_valid = 1'b0;
   endtask

   task automatic underflow_test(input int neff, input bit end_with_reset);
      int v1, v2, ev;
      v1 = gen_i();
      v2 = gen_i();
      flush();
      N = 10'(neff);
      I_IN = 12'(v1);
      s_valid = 1'b1;
      for (int t = 1; t <= 4 * neff; t++) begin
         step();
         if (t == 1) s_valid = 1'b0;
         if (t == 2 * neff + 2) s_valid = 1'b0;
         check_ctl("uflow", int'(t == neff || t == 3 * neff), int'(t >= 2 * neff));
         ev = 0;
         if (t >= neff + 2 && t <= 2 * neff + 1) ev = v1;
         if (t >= 3 * neff + 2) ev = v2;
         if (t >= 2) check_out("uflow", ev);
         if (t == 2 * neff + 1) begin
            I_IN = 12'(v2);
            s_valid = 1'b1;
         end
      end
      if (end_with_reset) begin
         RST = 1'b0;
         #1;
         check_out("rst_mid", 0);
         check_ctl("rst_mid", 0, 0);
         check("rst_mid_ready_en1", s_ready12, 1);
         en = 1'b0;
         #1;
         check("rst_mid_ready_en0", s_ready12, 0);
         en = 1'b1;
         step();
         RST = 1'b1;
         single_pair(gen_i(), gen_i(), 4, 1'b0);
      end else begin
         en = 1'b0;
         #1;
         check("en0_ready", s_ready12, 0);
         step();
         check_ctl("en0_a", 0, 0);
         step();
         check_out("en0_b", 0);
         en = 1'b1;
      end
   endtask

   task automatic nchange_test();
      int v;
      v = gen_i();
      flush();
      N = 10'd8;
      I_IN = 12'(v);
      s_valid = 1'b1;
      for (int t = 1; t <= 9; t++) begin
         step();
         if (t == 1) s_valid = 1'b0;
         check_ctl("nchg", int'(t == 6), int'(t >= 8));
         if (t >= 2) check_out("nchg", (t >= 8) ? v : 0);
         if (t == 5) N = 10'd2;
      end
   endtask

   task automatic rotation_test();
      int seq12[4];
      int seq10[4];
      int k12, k10;
      seq12[0] = exp_rf(1000, 300, AMP, 0, 12);  seq10[0] = exp_rf(1000, 300, AMP, 0, 10);
      seq12[1] = exp_rf(1000, 300, 0, AMP, 12);  seq10[1] = exp_rf(1000, 300, 0, AMP, 10);
      seq12[2] = exp_rf(1000, 300, -AMP, 0, 12); seq10[2] = exp_rf(1000, 300, -AMP, 0, 10);
      seq12[3] = exp_rf(1000, 300, 0, -AMP, 12); seq10[3] = exp_rf(1000, 300, 0, -AMP, 10);
      LO_fre = 32'h4000_0000;
      flush();
      N = 10'd64;
      I_IN = 12'sd1000;
      Q_IN = 12'sd300;
      s_valid = 1'b1;
      k12 = -1;
      k10 = -1;
      for (int t = 1; t <= 73; t++) begin
         step();
         if (t == 1) s_valid = 1'b0;
         if (t == 64) check("rot_tick", tick12, 1);
         if (t == 66) begin
            for (int k = 0; k < 4; k++) begin
               if (int'(rf12) == seq12[k]) k12 = k;
               if (int'(rf10) == seq10[k]) k10 = k;
            end
            check("rot_align12", int'(k12 >= 0), 1);
            check("rot_align10", int'(k10 >= 0), 1);
            if (k12 < 0) k12 = 0;
            if (k10 < 0) k10 = 0;
         end
         if (t > 66) begin
            check("rot_rf12", rf12, seq12[(k12 + t - 66) % 4]);
            check("rot_rf10", rf10, seq10[(k10 + t - 66) % 4]);
         end
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation still running, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      RST = 1'b0;
      en = 1'b1;
      s_valid = 1'b0;
      N = 10'd4;
      LO_fre = 32'h0;
      I_IN = '0;
      Q_IN = '0;
      repeat (3) step();
      check_out("rst", 0);
      check_ctl("rst", 0, 0);
      check("rst_ready12_en1", s_ready12, 1);
      check("rst_ready10_en1", s_ready10, 1);
      en = 1'b0;
      #1;
      check("rst_ready12_en0", s_ready12, 0);
      en = 1'b1;
      step();
      RST = 1'b1;
      single_pair(1000, 500, 4, 1'b0);
      single_pair(-1000, 500, 4, 1'b1);
      repeat (3) single_pair(gen_i(), gen_i(), int'($urandom_range(2, 7)), 1'b1);
      stream(4, 12);
      stream(1, 12);
      stream(0, 12);
      stream(int'($urandom_range(2, 7)), 10);
      underflow_test(4, 1'b0);
      underflow_test(int'($urandom_range(2, 6)), 1'b1);
      nchange_test();
      rotation_test();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
